flash_arbiter: RTL

FLASH_ARBITER -- requirements
Module: flash_arbiter

---
 rtl/flash_arbiter_pkg.sv | 14 +
 rtl/flash_arbiter_rr_pick2.sv | 21 ++
 rtl/flash_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/flash_arbiter_pkg.sv
// Shared definitions for the two-requester flash read arbiter.
package flash_arbiter_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_DELIVER = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_e;

endpackage

// File: rtl/flash_arbiter_rr_pick2.sv
// Two-way round-robin chooser: on a tie the requester not granted last wins.
module rr_pick2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic grant_o
);

   // grant index selection
   always_comb begin
      grant_o = 1'b0;
      if (req0_i && req1_i) begin
         grant_o = ~last_i;
      end else if (req1_i) begin
         grant_o = 1'b1;
      end else begin
         grant_o = 1'b0;
      end
   end

endmodule

// File: rtl/flash_arbiter.sv
// Arbitrates two byte-read requesters onto a single flash reader port.
module flash_arbiter
   import flash_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              req0Enable,
   input  logic [ADDR_W-1:0] req0Addr,
   output logic [DATA_W-1:0] req0Data,
   output logic              req0Ready,
   input  logic              req1Enable,
   input  logic [ADDR_W-1:0] req1Addr,
   output logic [DATA_W-1:0] req1Data,
   output logic              req1Ready,
   output logic [ADDR_W-1:0] flashReadAddr,
   output logic              flashEnable,
   input  logic [DATA_W-1:0] flashByte,
   input  logic              flashReady,
   output logic              grant,
   output logic              busy
);

   arb_state_e        state_q, state_d;
   logic              grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data0_q, data0_d;
   logic [DATA_W-1:0] data1_q, data1_d;
   logic              fen_q, fen_d;
   logic              rdy0_q, rdy0_d;
   logic              rdy1_q, rdy1_d;
   logic              busy_q, busy_d;
   logic              abort_q, abort_d;
   logic              pick_s;
   logic              gnt_en_s;

   rr_pick2 u_pick (
      .req0_i  (req0Enable),
      .req1_i  (req1Enable),
      .last_i  (grant_q),
      .grant_o (pick_s)
   );

   assign gnt_en_s = grant_q ? req1Enable : req0Enable;

   // next-state and registered-output computation
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      data0_d = data0_q;
      data1_d = data1_q;
      abort_d = abort_q;
      case (state_q)
         ST_IDLE: begin
            // a stale flashReady from before reset must clear before a grant
            if ((req0Enable || req1Enable) && !flashReady) begin
               grant_d = pick_s;
               addr_d  = pick_s ? req1Addr : req0Addr;
               abort_d = 1'b0;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (flashReady) begin
               if (abort_q || !gnt_en_s) begin
                  state_d = ST_RELEASE;
               end else begin
                  state_d = ST_DELIVER;
                  if (grant_q) begin
                     data1_d = flashByte;
                  end else begin
                     data0_d = flashByte;
                  end
               end
            end else if (!gnt_en_s) begin
               abort_d = 1'b1;
            end else begin
               abort_d = abort_q;
            end
         end
         ST_DELIVER: begin
            if (!gnt_en_s) begin
               state_d = ST_RELEASE;
            end else begin
               state_d = ST_DELIVER;
            end
         end
         ST_RELEASE: begin
            if (!flashReady) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RELEASE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      fen_d  = (state_d == ST_ISSUE);
      rdy0_d = (state_d == ST_DELIVER) && !grant_d;
      rdy1_d = (state_d == ST_DELIVER) && grant_d;
      busy_d = (state_d != ST_IDLE);
   end

   // state and output registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b1;
         addr_q  <= {ADDR_W{1'b0}};
         data0_q <= {DATA_W{1'b0}};
         data1_q <= {DATA_W{1'b0}};
         fen_q   <= 1'b0;
         rdy0_q  <= 1'b0;
         rdy1_q  <= 1'b0;
         busy_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         fen_q   <= fen_d;
         rdy0_q  <= rdy0_d;
         rdy1_q  <= rdy1_d;
         busy_q  <= busy_d;
         abort_q <= abort_d;
      end
   end

   assign flashReadAddr = addr_q;
   assign flashEnable   = fen_q;
   assign req0Data      = data0_q;
   assign req1Data      = data1_q;
   assign req0Ready     = rdy0_q;
   assign req1Ready     = rdy1_q;
   assign grant         = grant_q;
   assign busy          = busy_q;

endmodule
